// File: rtl/div_seq_ctrl.sv
// rtl/div_seq_ctrl.sv - multi-cycle non-restoring divider sequencer with HI/LO write enables
module div_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             flush,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             lo_en,
    output logic             hi_en
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_ITER,
        S_FIX,
        S_SIGN,
        S_DONE
    } state_t;

    state_t state, next_state;

    logic [WIDTH:0]   a_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] m_reg;
    logic [CNT_W-1:0] cnt;
    logic             sgn;
    logic             neg_q;
    logic             neg_r;
    logic             dz_reg;

    logic [WIDTH:0]   m_ext;
    logic [WIDTH:0]   a_shift;
    logic [WIDTH:0]   a_step;
    logic [WIDTH-1:0] q_abs;
    logic [WIDTH-1:0] m_abs;
    logic             last_iter;
    logic             finish;

    assign m_ext     = {1'b0, m_reg};
    assign a_shift   = {a_reg[WIDTH-1:0], q_reg[WIDTH-1]};
    // Sign of A before the shift picks add vs. subtract; the shifted value may
    // wrap but the post-step result always fits in WIDTH+1 bits.
    assign a_step    = a_reg[WIDTH] ? (a_shift + m_ext) : (a_shift - m_ext);
    assign q_abs     = (sgn && q_reg[WIDTH-1]) ? -q_reg : q_reg;
    assign m_abs     = (sgn && m_reg[WIDTH-1]) ? -m_reg : m_reg;
    assign last_iter = (cnt == CNT_W'(WIDTH - 1));
    assign finish    = (state == S_DONE) && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (start && !flush) next_state = S_PREP;
            S_PREP: next_state = (m_reg == '0) ? S_DONE : S_ITER;
            S_ITER: if (last_iter) next_state = S_FIX;
            S_FIX:  next_state = S_SIGN;
            S_SIGN: next_state = S_DONE;
            S_DONE: next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
        if (flush && state != S_IDLE) next_state = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg  <= '0;
            q_reg  <= '0;
            m_reg  <= '0;
            cnt    <= '0;
            sgn    <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dz_reg <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (next_state == S_PREP) begin
                        q_reg <= dividend;
                        m_reg <= divisor;
                        sgn   <= is_signed;
                    end
                end
                S_PREP: begin
                    neg_q <= sgn & (q_reg[WIDTH-1] ^ m_reg[WIDTH-1]);
                    neg_r <= sgn & q_reg[WIDTH-1];
                    cnt   <= '0;
                    if (m_reg == '0) begin
                        // Result registers double as the divide-by-zero answer.
                        q_reg  <= '1;
                        a_reg  <= {1'b0, q_reg};
                        dz_reg <= 1'b1;
                    end else begin
                        q_reg  <= q_abs;
                        m_reg  <= m_abs;
                        a_reg  <= '0;
                        dz_reg <= 1'b0;
                    end
                end
                S_ITER: begin
                    a_reg <= a_step;
                    q_reg <= {q_reg[WIDTH-2:0], ~a_step[WIDTH]};
                    cnt   <= cnt + CNT_W'(1);
                end
                S_FIX: begin
                    if (a_reg[WIDTH]) a_reg <= a_reg + m_ext;
                end
                S_SIGN: begin
                    q_reg  <= neg_q ? -q_reg : q_reg;
                    a_reg  <= {1'b0, (neg_r ? -a_reg[WIDTH-1:0] : a_reg[WIDTH-1:0])};
                    dz_reg <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            lo_en       <= 1'b0;
            hi_en       <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            busy  <= (next_state == S_PREP) || (next_state == S_ITER) ||
                     (next_state == S_FIX)  || (next_state == S_SIGN);
            done  <= finish;
            lo_en <= finish;
            hi_en <= finish;
            if (finish) begin
                quotient    <= q_reg;
                remainder   <= a_reg[WIDTH-1:0];
                div_by_zero <= dz_reg;
            end
        end
    end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// tb/tb_div_seq_ctrl.sv - scoreboard bench for div_seq_ctrl
module tb_div_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic        is_signed = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        busy, done, div_by_zero, lo_en, hi_en;
    logic [31:0] quotient, remainder;

    div_seq_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .flush(flush),
        .is_signed(is_signed), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero), .lo_en(lo_en), .hi_en(hi_en)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          exp_cyc;
    } sb_t;

    sb_t sb[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  done_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && done) begin
            sb_t e;
            done_cnt++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected no done", cyc);
            end else begin
                e = sb.pop_front();
                chk("quotient", quotient, e.q);
                chk("remainder", remainder, e.r);
                chk("div_by_zero", {31'b0, div_by_zero}, {31'b0, e.dz});
                chk("lo_en", {31'b0, lo_en}, 32'd1);
                chk("hi_en", {31'b0, hi_en}, 32'd1);
                chk("latency", cyc, e.exp_cyc);
            end
        end
    end

    task automatic do_op(input vec_t v);
        int bcnt = 0;
        int n = 0;
        @(negedge clk);
        is_signed = v.sgn;
        dividend  = v.a;
        divisor   = v.b;
        start     = 1'b1;
        sb.push_back('{v.q, v.r, v.dz, cyc + 1 + v.lat});
        @(negedge clk);
        start = 1'b0;
        while (sb.size() != 0 && n < 100) begin
            if (busy) bcnt++;
            @(negedge clk);
            #1;
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done after %0d cycles expected done", n);
            sb.delete();
        end
        chk("busy_cycles", bcnt, v.lat - 1);
    endtask

    vec_t vecs[13];

    initial begin
        vec_t v;
        int   d0;
        vecs[0]  = '{1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 36};
        vecs[1]  = '{1'b1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 36};
        vecs[2]  = '{1'b1, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2, 1'b0, 36};
        vecs[3]  = '{1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14, 32'hFFFFFFFE, 1'b0, 36};
        vecs[4]  = '{1'b0, 32'h12345678, 32'd0, 32'hFFFFFFFF, 32'h12345678, 1'b1, 2};
        vecs[5]  = '{1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 36};
        vecs[6]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0, 36};
        vecs[7]  = '{1'b0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0, 36};
        vecs[8]  = '{1'b0, 32'd5, 32'd9, 32'd0, 32'd5, 1'b0, 36};
        vecs[9]  = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 36};
        vecs[10] = '{1'b1, 32'h80000000, 32'd2, 32'hC0000000, 32'd0, 1'b0, 36};
        vecs[11] = '{1'b0, 32'h80000000, 32'd2, 32'h40000000, 32'd0, 1'b0, 36};
        vecs[12] = '{1'b1, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1, 2};

        repeat (3) @(negedge clk);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_done", {31'b0, done}, 32'd0);
        chk("reset_quotient", quotient, 32'd0);
        chk("reset_remainder", remainder, 32'd0);
        chk("reset_dz", {31'b0, div_by_zero}, 32'd0);
        chk("reset_en", {30'b0, lo_en, hi_en}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) do_op(vecs[i]);

        for (int i = 0; i < 12; i++) begin
            v.sgn = (i >= 6);
            v.a   = $urandom;
            v.b   = (i % 3 == 0) ? ($urandom & 32'hFF) : $urandom;
            if (v.b == 0) v.b = 32'd3;
            if (v.sgn && v.a == 32'h80000000 && v.b == 32'hFFFFFFFF) v.b = 32'd5;
            if (v.sgn) begin
                v.q = $signed(v.a) / $signed(v.b);
                v.r = $signed(v.a) % $signed(v.b);
            end else begin
                v.q = v.a / v.b;
                v.r = v.a % v.b;
            end
            v.dz  = 1'b0;
            v.lat = 36;
            do_op(v);
        end

        // start re-pulsed mid-operation must not queue a second op
        d0 = done_cnt;
        @(negedge clk);
        is_signed = 1'b0; dividend = 32'd200; divisor = 32'd3; start = 1'b1;
        sb.push_back('{32'd66, 32'd2, 1'b0, cyc + 37});
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        dividend = 32'd50; divisor = 32'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (60) @(negedge clk);
        chk("single_done", done_cnt - d0, 32'd1);
        chk("sb_drained", sb.size(), 32'd0);

        // flush mid-op: no done, outputs hold
        d0 = done_cnt;
        @(negedge clk);
        is_signed = 1'b0; dividend = 32'd1000; divisor = 32'd10; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (18) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", {31'b0, busy}, 32'd0);
        repeat (50) @(negedge clk);
        chk("flush_no_done", done_cnt - d0, 32'd0);
        chk("flush_q_hold", quotient, 32'd66);
        chk("flush_r_hold", remainder, 32'd2);

        // asynchronous reset mid-iteration
        @(negedge clk);
        is_signed = 1'b0; dividend = 32'd777; divisor = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'b0, busy}, 32'd0);
        chk("arst_done", {31'b0, done}, 32'd0);
        chk("arst_quotient", quotient, 32'd0);
        chk("arst_remainder", remainder, 32'd0);
        chk("arst_flags", {29'b0, div_by_zero, lo_en, hi_en}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        v = '{1'b0, 32'd81, 32'd9, 32'd9, 32'd0, 1'b0, 36};
        do_op(v);

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule

// File: doc/div_seq_ctrl.md
Name: div_seq_ctrl

Overview:
Multi-cycle sequencer for integer division (DIV instruction) in the CPU datapath. It runs non-restoring division one quotient bit per clock instead of through a fully unrolled combinational array. It handles signed and unsigned operands and divide-by-zero. It drives a start/busy/done handshake to the control unit and one-cycle write enables for the HI (remainder) and LO (quotient) registers.

Parameters:
WIDTH, 32, operand/result width in bits; must be >= 2.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request a division; sampled only in IDLE
flush  input  1  synchronous abort; returns to IDLE without done
is_signed  input  1  1 = two's-complement operands, 0 = unsigned; captured with start
dividend  input  WIDTH  Q operand; captured with start
divisor  input  WIDTH  M operand; captured with start
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse when results are valid
quotient  output  WIDTH  registered quotient, held until the next completion
remainder  output  WIDTH  registered remainder, held until the next completion
div_by_zero  output  1  registered flag for the last completed op; updates with done
lo_en  output  1  LO write enable; equals done
hi_en  output  1  HI write enable; equals done

Behaviour:
- Reset (async, rst_n=0): state=IDLE, counter=0, busy=0, done=0, lo_en=0, hi_en=0, quotient=0, remainder=0, div_by_zero=0, internal A/Q/M registers=0. Takes effect immediately, including mid-operation. No done is produced for the interrupted op.
- States: IDLE, PREP, ITER, FIX, SIGN, DONE.
- IDLE: if start=1, capture dividend, divisor and is_signed, then go to PREP. busy rises on the same edge.
- PREP (1 cycle):
  - Record neg_q = is_signed & (dividend[MSB] ^ divisor[MSB]) and neg_r = is_signed & dividend[MSB].
  - Replace each operand with its magnitude when is_signed and the MSB is set.
  - A (WIDTH+1 bits) = 0, counter = 0.
  - If divisor==0: go to DONE with quotient=all ones, remainder=original dividend, div_by_zero=1.
  - Otherwise go to ITER.
- ITER (exactly WIDTH cycles), per cycle:
  - Shift {A,Q} left by 1.
  - If A was non-negative before the shift, A = A - M; otherwise A = A + M.
  - Q[0] = ~A[MSB] (MSB taken after the add/subtract).
  - counter++. After WIDTH iterations (counter == WIDTH-1 on entry) go to FIX.
- FIX (1 cycle): if A is negative, A = A + M.
- SIGN (1 cycle): quotient = neg_q ? -Q : Q; remainder = neg_r ? -A[WIDTH-1:0] : A[WIDTH-1:0]; div_by_zero=0.
- DONE (1 cycle): done=1, lo_en=1, hi_en=1, busy=0; next state IDLE.
- Latency: start sampled at edge 0; done is high in the cycle following edge WIDTH+4 (36 cycles for WIDTH=32). Divide-by-zero path: done after edge 2.
- Signed rounding: truncate toward zero; the remainder takes the dividend's sign. Overflow case MIN/-1 gives quotient=MIN, remainder=0 with no flag (modular wrap).
- start while busy is ignored and not queued. start during the DONE cycle is also ignored; a new op may start in the next IDLE cycle.
- flush=1 in any non-IDLE state: next state IDLE, busy=0, no done/enables, outputs keep their previous values. flush has priority over start in IDLE.
- Outputs are registered only; no combinational path from inputs to outputs.

Test Plan:
- Unsigned 100 / 7, is_signed=0 -> one done pulse exactly 36 cycles after start; quotient=14, remainder=2, div_by_zero=0; busy high for 35 cycles; lo_en=hi_en=done.
- Signed -100 / 7 (0xFFFFFF9C / 0x00000007) -> quotient=0xFFFFFFF2 (-14), remainder=0xFFFFFFFE (-2). Then 100 / -7 -> quotient=-14, remainder=2.
- Divide by zero: 0x12345678 / 0 -> done 2 cycles after start; quotient=0xFFFFFFFF, remainder=0x12345678, div_by_zero=1. The next valid op clears the flag.
- Edge values, signed 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0. Unsigned 0xFFFFFFFF / 1 -> quotient=0xFFFFFFFF, remainder=0. 5 / 9 -> quotient=0, remainder=5.
- Pulse start again at cycle 10 of an op -> ignored, exactly one done. flush at cycle 20 -> busy drops next cycle, no done, outputs unchanged.
- Assert rst_n=0 asynchronously mid-ITER -> all outputs zero immediately. After release, a fresh 81/9 op gives quotient=9, remainder=0.
